// File: rtl/serving_wb_byte_bridge_pkg.sv
// Shared definitions for the serving byte bridge: FSM states and word/lane geometry.
package serving_wb_byte_bridge_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned LANE_W         = 2;
   localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_ACK
   } state_e;

endpackage

// File: rtl/serving_wb_byte_bridge.sv
// Wishbone-classic 32-bit slave that serialises each word access into four
// byte accesses on the 8-bit serving_ram port and reassembles read data.
module serving_wb_byte_bridge
   import serving_wb_byte_bridge_pkg::*;
#(
   parameter int unsigned depth = 256,
   parameter int unsigned aw    = $clog2(depth)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [aw-1:0]     i_wb_adr,
   input  logic [WORD_W-1:0] i_wb_dat,
   input  logic [3:0]        i_wb_sel,
   input  logic              i_wb_we,
   input  logic              i_wb_cyc,
   output logic [WORD_W-1:0] o_wb_rdt,
   output logic              o_wb_ack,
   output logic [aw-1:0]     o_waddr,
   output logic [7:0]        o_wdata,
   output logic              o_wen,
   output logic [aw-1:0]     o_raddr,
   output logic              o_ren,
   input  logic [7:0]        i_rdata,
   input  logic              i_ram_ack
);

   localparam int unsigned WAW = aw - LANE_W;

   state_e              state, state_n;
   logic [LANE_W-1:0]   k, k_n;
   logic [WAW-1:0]      adr_q, adr_n;
   logic [WORD_W-1:0]   dat_q, dat_n;
   logic [3:0]          sel_q, sel_n;
   logic [WORD_W-1:0]   rdt_n;
   logic                ack_n, wen_n, ren_n;
   logic [aw-1:0]       waddr_n, raddr_n;
   logic [7:0]          wdata_n;

   // Word-aligned access: the low address bits carry no information.
   logic unused_adr_bits;
   assign unused_adr_bits = ^i_wb_adr[LANE_W-1:0];

   // Next state plus next value of every registered output.
   always_comb begin
      state_n = state;
      k_n     = k;
      adr_n   = adr_q;
      dat_n   = dat_q;
      sel_n   = sel_q;
      rdt_n   = o_wb_rdt;
      ack_n   = 1'b0;
      wen_n   = 1'b0;
      ren_n   = 1'b0;
      waddr_n = o_waddr;
      wdata_n = o_wdata;
      raddr_n = o_raddr;

      case (state)
         ST_IDLE: begin
            if (i_wb_cyc) begin
               adr_n = i_wb_adr[aw-1:LANE_W];
               dat_n = i_wb_dat;
               sel_n = i_wb_sel;
               k_n   = '0;
               if (i_wb_we) begin
                  state_n = ST_WR;
                  wen_n   = i_wb_sel[0];
                  waddr_n = {i_wb_adr[aw-1:LANE_W], LANE_W'(0)};
                  wdata_n = i_wb_dat[7:0];
               end else begin
                  state_n = ST_RD_REQ;
                  ren_n   = 1'b1;
                  raddr_n = {i_wb_adr[aw-1:LANE_W], LANE_W'(0)};
               end
            end
         end
         ST_WR: begin
            if (!i_wb_cyc) begin
               state_n = ST_IDLE;
            end else if (k == LAST_LANE) begin
               state_n = ST_ACK;
               ack_n   = 1'b1;
            end else begin
               k_n     = k + LANE_W'(1);
               wen_n   = sel_q[k_n];
               waddr_n = {adr_q, k_n};
               wdata_n = dat_q[{k_n, 3'b000} +: 8];
            end
         end
         ST_RD_REQ: begin
            state_n = i_wb_cyc ? ST_RD_WAIT : ST_IDLE;
         end
         ST_RD_WAIT: begin
            if (!i_wb_cyc) begin
               state_n = ST_IDLE;
            end else if (i_ram_ack) begin
               rdt_n[{k, 3'b000} +: 8] = i_rdata;
               if (k == LAST_LANE) begin
                  state_n = ST_ACK;
                  ack_n   = 1'b1;
               end else begin
                  k_n     = k + LANE_W'(1);
                  state_n = ST_RD_REQ;
                  ren_n   = 1'b1;
                  raddr_n = {adr_q, k_n};
               end
            end
         end
         ST_ACK: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         k        <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         sel_q    <= '0;
         o_wb_rdt <= '0;
         o_wb_ack <= 1'b0;
         o_wen    <= 1'b0;
         o_ren    <= 1'b0;
         o_waddr  <= '0;
         o_raddr  <= '0;
         o_wdata  <= '0;
      end else begin
         state    <= state_n;
         k        <= k_n;
         adr_q    <= adr_n;
         dat_q    <= dat_n;
         sel_q    <= sel_n;
         o_wb_rdt <= rdt_n;
         o_wb_ack <= ack_n;
         o_wen    <= wen_n;
         o_ren    <= ren_n;
         o_waddr  <= waddr_n;
         o_raddr  <= raddr_n;
         o_wdata  <= wdata_n;
      end
   end

endmodule

// File: tb/tb_serving_wb_byte_bridge.sv
// Bench for serving_wb_byte_bridge: behavioural byte RAM with variable ack delay
// and a byte-array reference memory updated from Wishbone-level semantics.
module tb_serving_wb_byte_bridge;

   localparam int MAXC = 200;

   logic        clk = 1'b0;
   logic        rst, clr;
   logic [7:0]  i_wb_adr;
   logic [31:0] i_wb_dat;
   logic [3:0]  i_wb_sel;
   logic        i_wb_we, i_wb_cyc;
   logic [31:0] o_wb_rdt;
   logic        o_wb_ack;
   logic [7:0]  o_waddr, o_wdata, o_raddr;
   logic        o_wen, o_ren;
   logic [7:0]  rdata;
   logic        ram_ack;

   logic [7:0]  mem [256];
   logic [7:0]  ref_mem [256];
   int          ram_extra;
   logic        pend;
   logic [7:0]  paddr;
   int          cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serving_wb_byte_bridge #(.depth(256)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_wb_adr (i_wb_adr),
      .i_wb_dat (i_wb_dat),
      .i_wb_sel (i_wb_sel),
      .i_wb_we  (i_wb_we),
      .i_wb_cyc (i_wb_cyc),
      .o_wb_rdt (o_wb_rdt),
      .o_wb_ack (o_wb_ack),
      .o_waddr  (o_waddr),
      .o_wdata  (o_wdata),
      .o_wen    (o_wen),
      .o_raddr  (o_raddr),
      .o_ren    (o_ren),
      .i_rdata  (rdata),
      .i_ram_ack(ram_ack)
   );

   // Byte RAM: read data/ack arrive 1 + ram_extra cycles after the read strobe.
   always @(posedge clk) begin
      ram_ack <= 1'b0;
      if (clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         pend <= 1'b0;
         cnt  <= 0;
      end else begin
         if (o_wen) mem[o_waddr] <= o_wdata;
         if (o_ren) begin
            if (ram_extra == 0) begin
               ram_ack <= 1'b1;
               rdata   <= mem[o_raddr];
            end else begin
               pend  <= 1'b1;
               paddr <= o_raddr;
               cnt   <= ram_extra - 1;
            end
         end else if (pend) begin
            if (cnt == 0) begin
               pend    <= 1'b0;
               ram_ack <= 1'b1;
               rdata   <= mem[paddr];
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   function automatic logic [31:0] ref_word(input logic [7:0] adr);
      return {ref_mem[{adr[7:2], 2'd3}], ref_mem[{adr[7:2], 2'd2}],
              ref_mem[{adr[7:2], 2'd1}], ref_mem[{adr[7:2], 2'd0}]};
   endfunction

   function automatic logic [31:0] ram_word(input logic [7:0] adr);
      return {mem[{adr[7:2], 2'd3}], mem[{adr[7:2], 2'd2}],
              mem[{adr[7:2], 2'd1}], mem[{adr[7:2], 2'd0}]};
   endfunction

   // Issue one Wishbone transaction from a negedge; returns at the negedge of the ack cycle.
   task automatic txn(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdt, output int lat,
                      output logic [3:0] wl, output logic [3:0] rl, output int viol);
      int  n = 0;
      int  lane;
      bit  got = 1'b0;
      i_wb_we = we; i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel; i_wb_cyc = 1'b1;
      wl = '0; rl = '0; viol = 0; lat = -1; rdt = '0;
      while (!got && n < MAXC) begin
         @(posedge clk); @(negedge clk); n++;
         if (o_wen && o_ren) viol++;
         if (o_wen) begin
            lane = int'(o_waddr[1:0]);
            if (!we || o_waddr[7:2] != adr[7:2] || o_wdata != dat[8*lane +: 8]) viol++;
            wl[lane] = 1'b1;
         end
         if (o_ren) begin
            if (we || o_raddr[7:2] != adr[7:2]) viol++;
            rl[int'(o_raddr[1:0])] = 1'b1;
         end
         if (o_wb_ack) begin
            got = 1'b1;
            lat = n + 1;
            rdt = o_wb_rdt;
         end
      end
      if (we)
         for (int k = 0; k < 4; k++)
            if (sel[k]) ref_mem[{adr[7:2], 2'(k)}] = dat[8*k +: 8];
   endtask

   task automatic drop();
      i_wb_cyc = 1'b0; i_wb_we = 1'b0;
      @(posedge clk); @(negedge clk);
      tests++;
      if (o_wb_ack !== 1'b0) begin
         fails++; $display("FAIL extra_ack: got %b exp 0", o_wb_ack);
      end
   endtask

   task automatic test_reset();
      logic [31:0] r; int lat, v, acks; logic [3:0] wl, rl;
      rst = 1'b1; clr = 1'b1; i_wb_cyc = 1'b0; i_wb_we = 1'b0;
      i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0; ram_extra = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({o_wb_ack, o_wen, o_ren} !== 3'b000) begin
         fails++; $display("FAIL rst_strobes: got %b exp 000", {o_wb_ack, o_wen, o_ren});
      end
      tests++;
      if ({o_wb_rdt, o_waddr, o_raddr, o_wdata} !== 56'h0) begin
         fails++; $display("FAIL rst_data: got %h exp 0", {o_wb_rdt, o_waddr, o_raddr, o_wdata});
      end
      rst = 1'b0; clr = 1'b0;
      txn(1'b1, 8'h40, 32'h5A6B7C8D, 4'hF, r, lat, wl, rl, v);
      drop();
      // Start a read, then reset it after two bytes have been captured.
      i_wb_we = 1'b0; i_wb_adr = 8'h40; i_wb_cyc = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; i_wb_cyc = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); @(negedge clk);
         tests++;
         if ({o_wb_ack, o_wen, o_ren, o_wb_rdt, o_waddr, o_raddr, o_wdata} !== 59'h0) begin
            fails++; $display("FAIL rst_midread_c%0d: got %h exp 0", c,
                              {o_wb_ack, o_wen, o_ren, o_wb_rdt, o_waddr, o_raddr, o_wdata});
         end
      end
      rst = 1'b0;
      acks = 0;
      repeat (4) begin
         @(posedge clk); @(negedge clk);
         if (o_wb_ack || o_wen || o_ren) acks++;
      end
      tests++;
      if (acks !== 0) begin
         fails++; $display("FAIL rst_quiet: got %0d active cycles exp 0", acks);
      end
      txn(1'b0, 8'h40, 32'h0, 4'h0, r, lat, wl, rl, v);
      tests++;
      if (r !== 32'h5A6B7C8D || lat !== 10) begin
         fails++; $display("FAIL rst_recover: got %h lat %0d exp 5a6b7c8d lat 10", r, lat);
      end
      drop();
   endtask

   task automatic test_full_write();
      logic [31:0] r; int lat, v; logic [3:0] wl, rl;
      txn(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, r, lat, wl, rl, v);
      tests++;
      if (lat !== 6) begin fails++; $display("FAIL full_wr_lat: got %0d exp 6", lat); end
      tests++;
      if (wl !== 4'hF || v !== 0) begin
         fails++; $display("FAIL full_wr_lanes: got %b viol %0d exp 1111 viol 0", wl, v);
      end
      drop();
      tests++;
      if (ram_word(8'h10) !== 32'hDEADBEEF) begin
         fails++; $display("FAIL full_wr_ram: got %h exp deadbeef", ram_word(8'h10));
      end
   endtask

   task automatic test_partial_write();
      logic [31:0] r; int lat, v; logic [3:0] wl, rl;
      txn(1'b1, 8'h20, 32'h11223344, 4'hF, r, lat, wl, rl, v);
      drop();
      txn(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, r, lat, wl, rl, v);
      tests++;
      if (wl !== 4'b0101 || v !== 0 || lat !== 6) begin
         fails++; $display("FAIL part_wr_lanes: got %b viol %0d lat %0d exp 0101 0 6", wl, v, lat);
      end
      drop();
      tests++;
      if (ram_word(8'h20) !== 32'h11BB33DD) begin
         fails++; $display("FAIL part_wr_ram: got %h exp 11bb33dd", ram_word(8'h20));
      end
   endtask

   task automatic test_read();
      logic [31:0] r; int lat, v; logic [3:0] wl, rl;
      txn(1'b0, 8'h13, 32'h0, 4'h0, r, lat, wl, rl, v);
      tests++;
      if (r !== 32'hDEADBEEF) begin fails++; $display("FAIL read_data: got %h exp deadbeef", r); end
      tests++;
      if (lat !== 10) begin fails++; $display("FAIL read_lat: got %0d exp 10", lat); end
      tests++;
      if (rl !== 4'hF || wl !== 4'h0 || v !== 0) begin
         fails++; $display("FAIL read_lanes: got ren %b wen %b viol %0d exp 1111 0000 0", rl, wl, v);
      end
      drop();
   endtask

   task automatic test_abort();
      logic [31:0] r; int lat, v, act, n; logic [3:0] wl, rl;
      txn(1'b1, 8'h30, 32'hA5A5A5A5, 4'hF, r, lat, wl, rl, v);
      drop();
      i_wb_we = 1'b1; i_wb_adr = 8'h30; i_wb_dat = 32'h01020304; i_wb_sel = 4'hF; i_wb_cyc = 1'b1;
      n = 0;
      while (!(o_wen && o_waddr == 8'h31) && n < 20) begin
         @(posedge clk); @(negedge clk); n++;
      end
      tests++;
      if (n >= 20) begin fails++; $display("FAIL abort_lane1_seen: got timeout exp lane 1 write"); end
      i_wb_cyc = 1'b0; i_wb_we = 1'b0;
      act = 0;
      repeat (6) begin
         @(posedge clk); @(negedge clk);
         if (o_wb_ack || o_wen) act++;
      end
      tests++;
      if (act !== 0) begin fails++; $display("FAIL abort_wr_quiet: got %0d exp 0", act); end
      ref_mem[8'h30] = 8'h04;
      ref_mem[8'h31] = 8'h03;
      tests++;
      if (ram_word(8'h30) !== 32'hA5A50304) begin
         fails++; $display("FAIL abort_wr_ram: got %h exp a5a50304", ram_word(8'h30));
      end
      // Aborted read: the RAM ack lands while idle and must not touch read data.
      txn(1'b0, 8'h10, 32'h0, 4'h0, r, lat, wl, rl, v);
      drop();
      i_wb_adr = 8'h20; i_wb_cyc = 1'b1;
      @(posedge clk); @(negedge clk);
      i_wb_cyc = 1'b0;
      act = 0;
      repeat (5) begin
         @(posedge clk); @(negedge clk);
         if (o_wb_ack || o_ren) act++;
      end
      tests++;
      if (act !== 0 || o_wb_rdt !== 32'hDEADBEEF) begin
         fails++; $display("FAIL abort_rd: got act %0d rdt %h exp 0 deadbeef", act, o_wb_rdt);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r, d; int lat, v; logic [3:0] wl, rl;
      d = $urandom;
      txn(1'b1, 8'hFC, d, 4'hF, r, lat, wl, rl, v);
      tests++;
      if (lat !== 6 || v !== 0) begin fails++; $display("FAIL b2b_wr: got lat %0d viol %0d exp 6 0", lat, v); end
      txn(1'b0, 8'hFC, 32'h0, 4'hF, r, lat, wl, rl, v);
      tests++;
      if (r !== d) begin fails++; $display("FAIL b2b_rd_data: got %h exp %h", r, d); end
      tests++;
      if (lat !== 11 || rl !== 4'hF || v !== 0) begin
         fails++; $display("FAIL b2b_rd_timing: got lat %0d ren %b viol %0d exp 11 1111 0", lat, rl, v);
      end
      txn(1'b1, 8'hFE, ~d, 4'b1000, r, lat, wl, rl, v);
      drop();
      tests++;
      if (ram_word(8'hFC) !== ref_word(8'hFC) || ram_word(8'h00) !== ref_word(8'h00)) begin
         fails++; $display("FAIL b2b_top_ram: got %h/%h exp %h/%h", ram_word(8'hFC), ram_word(8'h00),
                           ref_word(8'hFC), ref_word(8'h00));
      end
   endtask

   task automatic test_random();
      logic [31:0] r, expw, dat; int lat, v, explat, extra, bad;
      logic [3:0] wl, rl, sel; logic we; logic [7:0] adr; bit prev_b2b;
      prev_b2b = 1'b0;
      for (int i = 0; i < 40; i++) begin
         we = 1'($urandom); adr = 8'($urandom); dat = $urandom; sel = 4'($urandom);
         extra = int'($urandom_range(0, 2));
         ram_extra = extra;
         expw = ref_word(adr);
         explat = (we ? 6 : 10 + 4 * extra) + (prev_b2b ? 1 : 0);
         txn(we, adr, dat, sel, r, lat, wl, rl, v);
         tests++;
         if (lat !== explat) begin fails++; $display("FAIL rnd%0d_lat: got %0d exp %0d", i, lat, explat); end
         tests++;
         if (we && (wl !== sel || rl !== 4'h0)) begin
            fails++; $display("FAIL rnd%0d_wr_lanes: got %b exp %b", i, wl, sel);
         end else if (!we && (r !== expw || rl !== 4'hF)) begin
            fails++; $display("FAIL rnd%0d_rd: got %h ren %b exp %h 1111", i, r, rl, expw);
         end
         tests++;
         if (v !== 0) begin fails++; $display("FAIL rnd%0d_bus: got %0d violations exp 0", i, v); end
         prev_b2b = ($urandom_range(0, 1) == 1);
         if (!prev_b2b) drop();
      end
      drop();
      bad = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL rnd_ram_image: got %0d bad bytes exp 0", bad); end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
      test_reset();
      test_full_write();
      test_partial_write();
      test_read();
      test_abort();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
